// File: rtl/multi_ch_record_unit_if.sv
// Output word stream of the multi-channel record unit: FIFO head, valid, ready.
interface multi_ch_record_unit_if #(
  parameter int NUM_CH = 4,
  parameter int WORD_W = 32
) ();

  logic [NUM_CH*WORD_W-1:0] wordOut;
  logic                     outValid;
  logic                     outReady;

  modport master (output wordOut, output outValid, input outReady);
  modport slave  (input wordOut, input outValid, output outReady);

endinterface : multi_ch_record_unit_if

// File: rtl/multi_ch_record_unit.sv
// Multi-channel serial recorder: shifts one bit per channel on each rising
// edge of samplePulse, packs WORD_W bits per channel into one entry and
// buffers entries in a first-word-fall-through FIFO with sticky overflow.
module multi_ch_record_unit #(
  parameter int NUM_CH     = 4,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             abort,
  input  logic                             samplePulse,
  input  logic [NUM_CH-1:0]                dIn,
  multi_ch_record_unit_if.master           out_if,
  output logic [$clog2(WORD_W+1)-1:0]      bitCount,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifoLevel,
  output logic                             overflow,
  input  logic                             clearOverflow
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BUS_W = NUM_CH * WORD_W;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic                prev_q, prev_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   acc_q [NUM_CH];
  logic [WORD_W-1:0]   acc_d [NUM_CH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                ovf_q, ovf_d;
  logic [BUS_W-1:0]    mem_q [FIFO_DEPTH];

  logic                shift_in;
  logic                push;
  logic                pop;
  logic                full;
  logic                do_write;
  logic [BUS_W-1:0]    push_word;

  // Strobe edge detect, per-channel shift and bit counting; a completed word
  // is pushed on the same edge that shifts in its last bit.
  always_comb begin
    prev_d    = samplePulse;
    shift_in  = enable & samplePulse & ~prev_q;
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    push      = 1'b0;
    if (abort) begin
      // abort wins over a coincident strobe: the partial word is discarded
      for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
      bit_cnt_d = '0;
    end else if (shift_in) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (LSB_FIRST) acc_d[c] = {dIn[c], acc_q[c][WORD_W-1:1]};
        else           acc_d[c] = {acc_q[c][WORD_W-2:0], dIn[c]};
      end
      if (bit_cnt_q == LAST_BIT) begin
        push      = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  // Pack the updated accumulators into one FIFO entry, channel c at c*WORD_W.
  always_comb begin
    push_word = '0;
    for (int c = 0; c < NUM_CH; c++) push_word[c*WORD_W +: WORD_W] = acc_d[c];
  end

  // FIFO pointer/level bookkeeping; a push into a full FIFO only lands if the
  // head is popped on the same edge, otherwise it is dropped and flagged.
  always_comb begin
    full     = (level_q == FULL_LVL);
    pop      = (level_q != '0) & out_if.outReady;
    do_write = push & (~full | pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (do_write) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_write && !pop)      level_d = level_q + LVL_W'(1);
    else if (!do_write && pop) level_d = level_q - LVL_W'(1);
    if (clearOverflow)       ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
  end

  // Control state registers with asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= 1'b0;
      bit_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
    end else begin
      prev_q    <= prev_d;
      bit_cnt_q <= bit_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      acc_q     <= acc_d;
    end
  end

  // FIFO storage write.
  // NOTE: the storage array has no reset; level_q gates every read, so stale
  // contents are never visible and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= push_word;
  end

  // First-word-fall-through head; zero whenever the FIFO is empty.
  always_comb begin
    out_if.outValid = (level_q != '0);
    out_if.wordOut  = '0;
    if (level_q != '0) out_if.wordOut = mem_q[rd_ptr_q];
  end

  assign bitCount  = bit_cnt_q;
  assign fifoLevel = level_q;
  assign overflow  = ovf_q;

endmodule : multi_ch_record_unit

// File: tb/tb_multi_ch_record_unit.sv
// Directed bench for multi_ch_record_unit (2 channels, 8-bit words, depth 4).
// An LSB-first instance is scoreboarded; an MSB-first twin shares the stimulus.
module tb_multi_ch_record_unit;

  localparam int NUM_CH     = 2;
  localparam int WORD_W     = 8;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        abort;
  logic        samplePulse;
  logic        clearOverflow;
  logic        out_ready;
  logic [1:0]  dIn;
  logic [3:0]  bc_l, bc_m;
  logic [2:0]  lvl_l, lvl_m;
  logic        ovf_l, ovf_m;

  multi_ch_record_unit_if #(.NUM_CH(NUM_CH), .WORD_W(WORD_W)) bus_l ();
  multi_ch_record_unit_if #(.NUM_CH(NUM_CH), .WORD_W(WORD_W)) bus_m ();

  assign bus_l.outReady = out_ready;
  assign bus_m.outReady = out_ready;

  multi_ch_record_unit #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .enable(enable), .abort(abort), .samplePulse(samplePulse),
    .dIn(dIn), .out_if(bus_l), .bitCount(bc_l), .fifoLevel(lvl_l), .overflow(ovf_l),
    .clearOverflow(clearOverflow));

  multi_ch_record_unit #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .enable(enable), .abort(abort), .samplePulse(samplePulse),
    .dIn(dIn), .out_if(bus_m), .bitCount(bc_m), .fifoLevel(lvl_m), .overflow(ovf_m),
    .clearOverflow(clearOverflow));

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] sb_q[$];
  int          sb_cnt = 0;
  logic [7:0]  sb_bits [2];
  logic        exp_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; any handshake at this edge is compared against the scoreboard.
  task automatic tick();
    if (bus_l.outValid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) check("pop_with_empty_sb", 64'(sb_q.size()), 64'd1);
      else                  check("pop_word", 64'(bus_l.wordOut), 64'(sb_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  // Rising strobe edge with model update (LSB-first: i-th bit lands in bit i).
  task automatic strobe_edge(input logic [1:0] d);
    logic        complete;
    logic        full_now;
    logic        popping;
    logic [15:0] word;
    dIn = d;
    samplePulse = 1'b1;
    complete = 1'b0;
    if (abort) begin
      sb_cnt = 0;
    end else if (enable) begin
      sb_bits[0][sb_cnt] = d[0];
      sb_bits[1][sb_cnt] = d[1];
      if (sb_cnt == 7) begin
        complete = 1'b1;
        sb_cnt = 0;
      end else begin
        sb_cnt++;
      end
    end
    full_now = (sb_q.size() == FIFO_DEPTH);
    popping  = bus_l.outValid && out_ready;
    word     = {sb_bits[1], sb_bits[0]};
    tick();
    if (complete) begin
      if (!full_now || popping) sb_q.push_back(word);
      else                      exp_ovf = 1'b1;
    end
  endtask

  task automatic strobe(input logic [1:0] d);
    strobe_edge(d);
    samplePulse = 1'b0;
    tick();
  endtask

  task automatic rand_bits(input int n);
    for (int i = 0; i < n; i++) strobe(2'($urandom_range(0, 3)));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && bus_l.outValid; i++) tick();
    out_ready = 1'b0;
    check("drain_valid_low", 64'(bus_l.outValid), 64'd0);
    check("drain_sb_left", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    reset = 1'b1; enable = 1'b1; abort = 1'b0; samplePulse = 1'b0;
    clearOverflow = 1'b0; out_ready = 1'b0; dIn = 2'b00;
    #2;
    check("rst_bitcount", 64'(bc_l), 64'd0);
    check("rst_level", 64'(lvl_l), 64'd0);
    check("rst_valid", 64'(bus_l.outValid), 64'd0);
    check("rst_overflow", 64'(ovf_l), 64'd0);
    check("rst_wordout", 64'(bus_l.wordOut), 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Known pattern: ch0 bits 1,0,1,1,0,0,0,0 and ch1 all ones.
    pat = 8'b0000_1101;
    for (int i = 0; i < 7; i++) strobe({1'b1, pat[i]});
    check("pre_push_valid", 64'(bus_l.outValid), 64'd0);
    strobe_edge({1'b1, pat[7]});
    check("push_valid", 64'(bus_l.outValid), 64'd1);
    check("lsb_word", 64'(bus_l.wordOut), 64'h0000_0000_0000_FF0D);
    check("msb_word", 64'(bus_m.wordOut), 64'h0000_0000_0000_FFB0);
    check("push_level", 64'(lvl_l), 64'd1);
    samplePulse = 1'b0;
    tick();
    drain();

    // Held strobe level gives exactly one shift.
    check("held_start", 64'(bc_l), 64'd0);
    dIn = 2'b11;
    samplePulse = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("held_one_shift", 64'(bc_l), 64'd1);
    samplePulse = 1'b0;
    tick();
    check("held_release", 64'(bc_l), 64'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    sb_cnt = 0;
    check("abort_clears", 64'(bc_l), 64'd0);

    // Five words into a stalled FIFO: fifth is dropped.
    for (int w = 0; w < 5; w++) rand_bits(8);
    check("ovf_level", 64'(lvl_l), 64'd4);
    check("ovf_set", 64'(ovf_l), 64'(exp_ovf));
    check("ovf_valid", 64'(bus_l.outValid), 64'd1);
    drain();
    check("ovf_sticky", 64'(ovf_l), 64'd1);
    clearOverflow = 1'b1; tick(); clearOverflow = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_cleared", 64'(ovf_l), 64'(exp_ovf));

    // Full FIFO, pop coincident with completing push.
    for (int w = 0; w < 4; w++) rand_bits(8);
    rand_bits(7);
    check("full_before", 64'(lvl_l), 64'd4);
    out_ready = 1'b1;
    strobe_edge(2'($urandom_range(0, 3)));
    out_ready = 1'b0;
    samplePulse = 1'b0;
    tick();
    check("pushpop_level", 64'(lvl_l), 64'd4);
    check("pushpop_no_ovf", 64'(ovf_l), 64'd0);
    drain();

    // Enable gap preserves the partial word.
    rand_bits(3);
    enable = 1'b0;
    rand_bits(10);
    check("disabled_hold", 64'(bc_l), 64'd3);
    enable = 1'b1;
    rand_bits(5);
    check("resume_level", 64'(lvl_l), 64'd1);
    drain();

    // Abort with coincident strobe discards the partial word.
    rand_bits(3);
    abort = 1'b1;
    strobe_edge(2'b11);
    abort = 1'b0;
    samplePulse = 1'b0;
    tick();
    check("abort_bitcount", 64'(bc_l), 64'd0);
    rand_bits(8);
    check("post_abort_level", 64'(lvl_l), 64'd1);
    drain();

    // Asynchronous reset mid-word with buffered data.
    rand_bits(16);
    rand_bits(5);
    check("mid_bitcount", 64'(bc_l), 64'd5);
    check("mid_level", 64'(lvl_l), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    check("async_bitcount", 64'(bc_l), 64'd0);
    check("async_level", 64'(lvl_l), 64'd0);
    check("async_valid", 64'(bus_l.outValid), 64'd0);
    check("async_wordout", 64'(bus_l.wordOut), 64'd0);
    check("async_msb_state", 64'({bc_m, lvl_m, ovf_m, bus_m.wordOut}), 64'd0);
    sb_q.delete();
    sb_cnt = 0;
    exp_ovf = 1'b0;
    dIn = 2'b01;
    samplePulse = 1'b1;
    tick();
    #2;
    reset = 1'b0;
    strobe_edge(2'b01);
    check("release_edge_counts", 64'(bc_l), 64'd1);
    samplePulse = 1'b0;
    tick();
    check("release_no_ovf", 64'(ovf_l), 64'(exp_ovf));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_multi_ch_record_unit
